// File: rtl/tempo_estimator_if.sv
// Beat strobe in, BPM word out, between the beat detector and the visual controllers.
interface tempo_estimator_if;
    logic       beat_in;
    logic [9:0] tempo;
    logic       tempo_valid;
    logic       busy;

    modport master (
        output beat_in,
        input  tempo,
        input  tempo_valid,
        input  busy
    );

    modport slave (
        input  beat_in,
        output tempo,
        output tempo_valid,
        output busy
    );
endinterface

// File: rtl/tempo_estimator.sv
// Beat-interval tempo estimator: averages the last 4 beat periods and
// converts the average to BPM with a 32-step restoring divider.
module tempo_estimator #(
    parameter int CLK_HZ    = 27000000,
    parameter int TEMPO_MIN = 59,
    parameter int TEMPO_MAX = 240
) (
    input  logic             clk,
    input  logic             reset,
    tempo_estimator_if.slave bus
);
    localparam longint      NUM_L      = 64'(60) * CLK_HZ;
    localparam logic [31:0] NUM        = 32'(NUM_L);
    localparam logic [31:0] MIN_PERIOD = 32'(NUM_L / TEMPO_MAX);
    localparam logic [31:0] MAX_PERIOD = 32'(NUM_L / TEMPO_MIN);

    localparam logic [1:0] WAIT_FIRST = 2'd0;
    localparam logic [1:0] MEASURE    = 2'd1;
    localparam logic [1:0] DIVIDE     = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    logic [1:0]  state;
    logic        beat_q;
    logic        beat_edge;
    logic [31:0] cnt;
    logic [31:0] hist [4];
    logic [31:0] hist_n [4];
    logic        hist_vld;
    logic        pending;
    logic [33:0] sum;
    logic [31:0] avg_n;
    logic        timeout;
    logic        valid_beat;

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic [4:0]  iter;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] rem_n;

    logic [9:0]  tempo_r;
    logic        valid_r;

    assign beat_edge  = bus.beat_in & ~beat_q;
    assign timeout    = (state != WAIT_FIRST) && (cnt > MAX_PERIOD);
    assign valid_beat = (state != WAIT_FIRST) && beat_edge &&
                        !timeout && (cnt >= MIN_PERIOD);

    // An empty history is preloaded so the first estimate is not diluted.
    always_comb begin
        hist_n = hist;
        if (valid_beat) begin
            if (!hist_vld) begin
                for (int i = 0; i < 4; i++) hist_n[i] = cnt;
            end else begin
                hist_n[0] = cnt;
                for (int i = 1; i < 4; i++) hist_n[i] = hist[i-1];
            end
        end
    end

    assign sum   = 34'(hist_n[0]) + 34'(hist_n[1]) +
                   34'(hist_n[2]) + 34'(hist_n[3]);
    assign avg_n = 32'(sum >> 2);

    assign trial = {rem, quo[31]};
    assign ge    = trial >= {1'b0, dvsr};
    assign rem_n = ge ? 32'(trial - {1'b0, dvsr}) : trial[31:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_FIRST;
            beat_q   <= 1'b0;
            cnt      <= '0;
            hist_vld <= 1'b0;
            pending  <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            iter     <= '0;
            tempo_r  <= '0;
            valid_r  <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            beat_q  <= bus.beat_in;
            valid_r <= 1'b0;
            if (timeout) begin
                // A coincident edge still counts as the first beat.
                tempo_r  <= '0;
                valid_r  <= 1'b1;
                hist_vld <= 1'b0;
                pending  <= 1'b0;
                for (int i = 0; i < 4; i++) hist[i] <= '0;
                state <= beat_edge ? MEASURE : WAIT_FIRST;
                cnt   <= beat_edge ? 32'd1 : 32'd0;
            end else begin
                if (state != WAIT_FIRST) cnt <= cnt + 32'd1;
                if (valid_beat) begin
                    hist     <= hist_n;
                    hist_vld <= 1'b1;
                    cnt      <= 32'd1;
                end
                case (state)
                    WAIT_FIRST: begin
                        if (beat_edge) begin
                            cnt   <= 32'd1;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (valid_beat) begin
                            rem   <= '0;
                            quo   <= NUM;
                            dvsr  <= avg_n;
                            iter  <= '0;
                            state <= DIVIDE;
                        end
                    end
                    DIVIDE: begin
                        rem  <= rem_n;
                        quo  <= {quo[30:0], ge};
                        iter <= iter + 5'd1;
                        if (valid_beat) pending <= 1'b1;
                        if (iter == 5'd31) state <= DONE;
                    end
                    default: begin
                        tempo_r <= (quo > 32'd1023) ? 10'd1023 : quo[9:0];
                        valid_r <= 1'b1;
                        if (pending || valid_beat) begin
                            pending <= 1'b0;
                            rem     <= '0;
                            quo     <= NUM;
                            dvsr    <= avg_n;
                            iter    <= '0;
                            state   <= DIVIDE;
                        end else begin
                            state <= MEASURE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.tempo       = tempo_r;
    assign bus.tempo_valid = valid_r;
    assign bus.busy        = (state == DIVIDE);
endmodule

// File: tb/tb_tempo_estimator.sv
// Directed bench for tempo_estimator: beat-period vector table on a
// TEMPO_MAX=240 instance plus hand sequences on a TEMPO_MAX=2000 instance.
module tb_tempo_estimator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tempo_estimator_if ifa ();
    tempo_estimator_if ifb ();

    tempo_estimator #(
        .CLK_HZ(1000), .TEMPO_MIN(59), .TEMPO_MAX(240)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    tempo_estimator #(
        .CLK_HZ(1000), .TEMPO_MIN(59), .TEMPO_MAX(2000)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    typedef struct {
        int at;
        int val;
    } ev_t;

    typedef struct {
        int gap;
        bit tmo;
        bit upd;
        int tempo;
    } vec_t;

    ev_t  qa[$];
    ev_t  qb[$];
    vec_t tbl[16];
    int   ncyc   = 0;
    int   nvec   = 0;
    int   nerr   = 0;
    int   busy_a = 0;
    int   b2b    = 0;
    int   cur    = 0;
    bit   pva    = 1'b0;
    bit   pvb    = 1'b0;

    task automatic tick();
        ev_t e;
        @(negedge clk);
        ncyc++;
        if (ifa.tempo_valid) begin
            e.at = ncyc;
            e.val = int'(ifa.tempo);
            qa.push_back(e);
            if (pva) b2b++;
        end
        if (ifb.tempo_valid) begin
            e.at = ncyc;
            e.val = int'(ifb.tempo);
            qb.push_back(e);
            if (pvb) b2b++;
        end
        pva = ifa.tempo_valid;
        pvb = ifb.tempo_valid;
        if (ifa.busy) busy_a++;
    endtask

    task automatic wait_until(input int n);
        while (ncyc < n) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic raise(input bit on_b, output int r);
        if (on_b) ifb.beat_in = 1'b1;
        else ifa.beat_in = 1'b1;
        r = ncyc;
        tick();
        ifa.beat_in = 1'b0;
        ifb.beat_in = 1'b0;
    endtask

    initial begin
        int last;
        int r;
        int r2;
        int r3;

        // gap = cycles since previous edge on dut_a
        tbl[0]  = '{10,   1'b0, 1'b0, 0};
        tbl[1]  = '{500,  1'b0, 1'b1, 120};
        tbl[2]  = '{500,  1'b0, 1'b1, 120};
        tbl[3]  = '{100,  1'b0, 1'b0, 0};
        tbl[4]  = '{400,  1'b0, 1'b1, 120};
        tbl[5]  = '{500,  1'b0, 1'b1, 120};
        tbl[6]  = '{400,  1'b0, 1'b1, 126};
        tbl[7]  = '{400,  1'b0, 1'b1, 133};
        tbl[8]  = '{400,  1'b0, 1'b1, 141};
        tbl[9]  = '{400,  1'b0, 1'b1, 150};
        tbl[10] = '{500,  1'b0, 1'b1, 141};
        tbl[11] = '{500,  1'b0, 1'b1, 133};
        tbl[12] = '{500,  1'b0, 1'b1, 126};
        tbl[13] = '{500,  1'b0, 1'b1, 120};
        tbl[14] = '{1100, 1'b1, 1'b0, 0};
        tbl[15] = '{300,  1'b0, 1'b1, 200};

        reset = 1'b1;
        ifa.beat_in = 1'b0;
        ifb.beat_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset a tempo", int'(ifa.tempo), 0);
        chk("reset a valid", int'(ifa.tempo_valid), 0);
        chk("reset a busy", int'(ifa.busy), 0);
        chk("reset b tempo", int'(ifb.tempo), 0);
        chk("reset b valid", int'(ifb.tempo_valid), 0);
        chk("reset b busy", int'(ifb.busy), 0);
        qa.delete();
        qb.delete();

        last = ncyc;
        for (int i = 0; i < 16; i++) begin
            wait_until(last + tbl[i].gap);
            if (tbl[i].tmo) begin
                // timeout is decided on the edge where the counter reads 1017
                chk($sformatf("v%0d timeout count", i), qa.size(), 1);
                if (qa.size() > 0) begin
                    chk($sformatf("v%0d timeout at", i), qa[0].at - last, 1018);
                    chk($sformatf("v%0d timeout tempo", i), qa[0].val, 0);
                end
                cur = 0;
            end else begin
                chk($sformatf("v%0d idle pulses", i), qa.size(), 0);
            end
            qa.delete();
            busy_a = 0;
            raise(1'b0, r);
            last = r;
            wait_until(r + 40);
            if (tbl[i].upd) begin
                chk($sformatf("v%0d count", i), qa.size(), 1);
                if (qa.size() > 0) begin
                    chk($sformatf("v%0d latency", i), qa[0].at - r, 34);
                    chk($sformatf("v%0d tempo", i), qa[0].val, tbl[i].tempo);
                end
                chk($sformatf("v%0d busy len", i), busy_a, 32);
                cur = tbl[i].tempo;
            end else begin
                chk($sformatf("v%0d count", i), qa.size(), 0);
            end
            chk($sformatf("v%0d held", i), int'(ifa.tempo), cur);
            qa.delete();
        end

        // reset 10 cycles into a division
        wait_until(last + 300);
        raise(1'b0, r);
        wait_until(r + 10);
        chk("pre-reset busy", int'(ifa.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy", int'(ifa.busy), 0);
        chk("rst tempo", int'(ifa.tempo), 0);
        chk("rst valid", int'(ifa.tempo_valid), 0);
        wait_until(r + 100);
        chk("rst no pulse", qa.size(), 0);
        raise(1'b0, r);
        wait_until(r + 40);
        chk("rst first beat", qa.size(), 0);
        wait_until(r + 300);
        raise(1'b0, r);
        wait_until(r + 40);
        chk("rst second count", qa.size(), 1);
        if (qa.size() > 0) chk("rst second tempo", qa[0].val, 200);
        qa.delete();

        // saturation at MIN_PERIOD=30, then a pending beat
        qb.delete();
        raise(1'b1, r);
        wait_until(r + 30);
        raise(1'b1, r2);
        wait_until(r2 + 30);
        raise(1'b1, r3);
        wait_until(r2 + 80);
        chk("sat count", qb.size(), 2);
        if (qb.size() == 2) begin
            chk("sat1 at", qb[0].at - r2, 34);
            chk("sat1 tempo", qb[0].val, 1023);
            chk("sat2 at", qb[1].at - r2, 67);
            chk("sat2 tempo", qb[1].val, 1023);
        end
        qb.delete();
        wait_until(r3 + 1030);
        chk("b timeout count", qb.size(), 1);
        if (qb.size() > 0) begin
            chk("b timeout at", qb[0].at - r3, 1018);
            chk("b timeout tempo", qb[0].val, 0);
        end
        qb.delete();

        // pending with distinct averages: 200 x4, then 30 -> avg 157
        raise(1'b1, r);
        wait_until(r + 200);
        raise(1'b1, r2);
        wait_until(r2 + 30);
        raise(1'b1, r3);
        wait_until(r2 + 80);
        chk("pend count", qb.size(), 2);
        if (qb.size() == 2) begin
            chk("pend1 at", qb[0].at - r2, 34);
            chk("pend1 tempo", qb[0].val, 300);
            chk("pend2 at", qb[1].at - r2, 67);
            chk("pend2 tempo", qb[1].val, 382);
        end
        chk("pend held", int'(ifb.tempo), 382);

        chk("back-to-back valid", b2b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
